gen_serial_rx: RTL
==================

// Module: gen_serial_rx
// PURPOSE
//  Receiver end of the one-bit-per-clock framed serial link used by the generate diags.
//  Deserializes start/data/[parity]/stop frames from a single line into a parallel word.
//  Holds each word under a valid/ack handshake.
//  Bit order and parity checking are chosen per instance through generate if/else on
//  parameters, so two instances with different parameters exercise merging of differing
//  generate scopes.
// PARAMETERS
//  WIDTH      8  data bits per frame, legal 1..16
//  MSB_FIRST  0  0: first data bit is data[0]; 1: first data bit is data[WIDTH-1]
//  PARITY     0  0: no parity bit; 1: even-parity bit follows the data bits
// PORTS
//  clock     input   1      rising-edge clock, sole clock domain
//  reset     input   1      synchronous, active-high reset
//  rx        input   1      serial line, idles high, sampled every rising clock edge
//  ack       input   1      consumer accepts data while valid is high
//  data      output  WIDTH  last good received word
//  valid     output  1      data holds an unacknowledged word
//  err       output  1      one-cycle pulse on framing or parity error
//  overrun   output  1      sticky; a good frame completed while valid was high
// BEHAVIOUR
//  Reset: state=IDLE, bit counter=0, shift reg=0, data=0, valid=0, err=0, overrun=0.
//   Reset wins over every other event in the same cycle, including mid-frame; the partial
//   frame is discarded.
//  States:
//   IDLE: rx==0 -> DATA, counter cleared. rx==1 -> stay in IDLE.
//   DATA: shift rx in each cycle; counter counts 0..WIDTH-1. After WIDTH bits -> PAR if
//    PARITY==1, else -> STOP.
//   PAR: sample the parity bit -> STOP. A parity mismatch is recorded in a flag.
//    The mismatch test is XOR of the data bits and the parity bit being 1.
//   STOP: sample the stop bit -> IDLE. The next start bit can be sampled on the very next
//    cycle, so back-to-back frames carry no idle gap.
//  Shift direction comes from the generate branch on MSB_FIRST.
//   LSB-first: sr = {rx, sr[WIDTH-1:1]}.
//   MSB-first: sr = {sr[WIDTH-2:0], rx}; for WIDTH==1 both branches reduce to sr = rx.
//  With PARITY==0, no PAR state logic and no parity flag are generated.
//  Frame outcome, on the edge that samples the stop bit:
//   - stop==1 and no parity error: data<=sr and valid<=1 on that edge, so valid is high in
//     the next cycle. Latency from the start-bit edge is WIDTH+2 clocks, or WIDTH+3 with
//     parity. If valid was already 1 and not being acked that cycle: overrun<=1, and data is
//     still overwritten (newest word wins).
//   - stop==0 or parity error: err pulses high for exactly one cycle; data, valid and
//     overrun are unchanged.
//  Handshake:
//   - valid clears on the edge where valid==1 and ack==1.
//   - ack while valid==0 is ignored.
//   - Ack and a good frame completing in the same cycle: valid stays 1, data takes the new
//     word, no overrun.
//  overrun clears only on reset.
//  A start bit is never detected outside IDLE; rx in DATA/PAR/STOP is always payload.
//  All outputs are registered; no combinational path from rx or ack to any output.
// TESTING
//  1. Reset release: rx=1 for 5 clocks -> data=0, valid=0, err=0, overrun=0.
//  2. WIDTH=8, MSB_FIRST=0, PARITY=0: rx=0, then 1,0,1,0,0,1,0,1, then stop 1.
//     Required: data=8'hA5, valid=1 from 10 clocks after the start edge; ack=1 clears valid
//     one edge later.
//  3. Second instance with MSB_FIRST=1, same bit stream -> data=8'hA5 reversed = 8'hA5
//     (palindrome). Then send 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 gives 8'hC0, MSB_FIRST=0
//     gives 8'h03.
//  4. PARITY=1, data 8'h07 with parity 1 (good) -> valid, data=8'h07. Same data with
//     parity 0 -> err one-cycle pulse, valid unchanged.
//  5. Stop bit 0 -> err pulse, data unchanged. Two good frames back-to-back with no ack ->
//     overrun=1, data=second word. Repeat with ack asserted on the completion cycle ->
//     overrun stays 0.
//  6. reset=1 at data bit 4 of a frame, rx held 1 afterwards -> IDLE, no valid, no err.
//     Next full frame decodes correctly.

Source files
------------

// File: rtl/gen_serial_rx.sv
// gen_serial_rx: framed one-bit-per-clock serial receiver with valid/ack word hand-off
//   clock, reset : rising-edge clock, synchronous active-high reset
//   rx           : serial line (idles high), ack: consumer accepts data while valid
//   data, valid  : last good word and its pending flag
//   err          : one-cycle pulse on framing/parity error; overrun: sticky lost-word flag
module gen_serial_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_perr;
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sr_next = rx;
    end else if (MSB_FIRST) begin : g_msb
      assign w_sr_next = {r_sr[WIDTH-2:0], rx};
    end else begin : g_lsb
      assign w_sr_next = {rx, r_sr[WIDTH-1:1]};
    end
    if (PARITY) begin : g_par
      logic r_perr;
      // even parity: data bits XOR parity bit must be 0
      always_ff @(posedge clock)
        if (reset) r_perr <= 1'b0;
        else if (r_state == PAR) r_perr <= ^r_sr ^ rx;
      assign w_perr = r_perr;
    end else begin : g_nopar
      assign w_perr = 1'b0;
    end
  endgenerate
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      data    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err <= 1'b0;
      if (valid && ack) valid <= 1'b0;
      case (r_state)
        IDLE: if (!rx) begin
          r_state <= DATA;
          r_cnt   <= '0;
        end
        DATA: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(WIDTH - 1)) r_state <= PARITY ? PAR : STOP;
        end
        PAR: r_state <= STOP;
        default: begin
          r_state <= IDLE;
          if (rx && !w_perr) begin
            data  <= r_sr;
            valid <= 1'b1;
            if (valid && !ack) overrun <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
